irq_trap_ctrl: RTL
==================

Name: irq_trap_ctrl

Overview:
- Parametrised machine-mode interrupt and trap controller for the 5-stage core.
- Owns the interrupt CSRs (mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause), a free-running timer with a compare register, and NUM_IRQ external level interrupt lines.
- Arbitrates pending interrupts, requests a pipeline redirect through a req/ack handshake with pipe_ctrl, and saves or restores trap state on entry and on mret.

Parameters:
- NUM_IRQ, 8, external interrupt lines (1..16).
- DATA_WIDTH, 32, CSR data width.
- ADDR_WIDTH, 32, PC width.
- CSR_ADDR_WIDTH, 12, CSR address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- irq_i  in  NUM_IRQ  external interrupt levels, asynchronous to clk_i
- csr_raddr_i  in  CSR_ADDR_WIDTH  read address from exe
- csr_rdata_o  out  DATA_WIDTH  combinational read data, 0 for unmapped addresses
- csr_we_i  in  1  write enable from the WB stage
- csr_waddr_i  in  CSR_ADDR_WIDTH  write address
- csr_wdata_i  in  DATA_WIDTH  write data
- inst_valid_i  in  1  a committable instruction is in EXE and may be interrupted
- epc_i  in  ADDR_WIDTH  PC of that instruction
- mret_i  in  1  one-cycle pulse when mret executes
- trap_req_o  out  1  redirect request to pipe_ctrl
- trap_addr_o  out  ADDR_WIDTH  redirect target
- trap_ack_i  in  1  pipe_ctrl has flushed and taken the redirect
- mepc_o  out  ADDR_WIDTH  current mepc, used as the mret target

Behaviour:
- Reset (rst_i=0, asynchronous):
  - registers: MIE=0, MPIE=0, mie=0, mtvec=0, mepc=0, mcause=0, mtime=0, mtimecmp=all-ones, synchronisers=0, state=IDLE.
  - outputs: trap_req_o=0, trap_addr_o=0, mepc_o=0.
- CSR map (all other addresses read 0 and ignore writes):
  - 0x300 mstatus: bit3 MIE, bit7 MPIE.
  - 0x304 mie: bit7 MTIE; bit 16+k enables irq k.
  - 0x344 mip: read-only, same layout as mie.
  - 0x305 mtvec: bits[1:0] are mode.
  - 0x341 mepc: bits[1:0] forced to 0.
  - 0x342 mcause.
  - 0x7C0 mtime: read-only.
  - 0x7C1 mtimecmp.
- Timer:
  - mtime increments by 1 every cycle and wraps at 2^DATA_WIDTH.
  - MTIP = (mtime >= mtimecmp), unsigned; it is combinational from the registers.
  - A write to mtimecmp updates MTIP from the following cycle.
- External interrupts:
  - irq_i passes through a 2-flop synchroniser, giving 2 cycles from an input edge to the mip bit.
  - Inputs are level-sensitive with no latching: a line dropped before the trap is taken cancels the request.
- Arbitration:
  - enabled = mip & mie.
  - Priority: MTIP first, then the lowest-index irq.
  - Cause codes: timer = 7; irq k = 16+k.
- FSM IDLE -> REQ:
  - Condition: MIE=1, enabled!=0, inst_valid_i=1, mret_i=0.
  - On that edge, cause and trap_addr_o are captured.
- REQ:
  - trap_req_o=1 and trap_addr_o is held stable until trap_ack_i.
  - Sources are not re-arbitrated while in REQ, even if the chosen source deasserts.
  - On the trap_ack_i cycle: mepc<=epc_i (sampled in the ack cycle), mcause<={1'b1, cause}, MPIE<=MIE, MIE<=0, then return to IDLE with trap_req_o=0 next cycle.
- mret_i:
  - Effect: MIE<=MPIE, MPIE<=1.
  - mret_i is ignored while in REQ, because pipe_ctrl flushes it.
  - In IDLE, mret_i in the same cycle as the take condition wins; the trap is re-evaluated the next cycle with the restored MIE.
- Write conflicts:
  - A CSR write to mstatus, mepc or mcause in the trap_ack_i cycle loses to the trap update.
  - A CSR write to mstatus in an mret_i cycle loses to the mret update.
- Back-to-back interrupts: the earliest next trap is the cycle after MIE returns to 1.
- Reset asserted in REQ aborts the request immediately.

Optional Feature:
- Macro: VECTORED_MODE_EN.
- Defined: when mtvec[1:0]=01, an interrupt targets {mtvec[ADDR_WIDTH-1:2],2'b00} + 4*cause. Mode 00 targets the base address.
- Undefined: mtvec[1:0] read as 0 and ignore writes; every trap targets the base address.

Test Plan:
- Timer trap:
  - Stimulus: mtvec=0x100, mie=0x80, MIE=1, mtimecmp=20, inst_valid_i=1, epc_i=0x40, ack 2 cycles after the request.
  - Required: trap_req_o rises on the first cycle with mtime>=20; trap_addr_o=0x100; after ack, mepc=0x40, mcause=0x80000007, MIE=0, MPIE=1.
- Priority:
  - Stimulus: irq_i=0b0110 with mie bits 17 and 18 set, and the timer pending with MTIE=1.
  - Required: cause 7 is taken first; after mret and re-enable, cause 17 (0x80000011) is taken.
- Masking and cancellation:
  - Stimulus: irq_i[0]=1 with MIE=0 -> required: no request, mip bit16=1 two cycles later.
  - Stimulus: irq_i[0] dropped before MIE is set -> required: no trap.
- mret collision:
  - Stimulus: mret_i and the take condition in the same cycle, with MPIE=1.
  - Required: no request that cycle; trap_req_o=1 the next cycle; MIE=1 before entry.
- Reset mid-handshake:
  - Stimulus: rst_i=0 while in REQ.
  - Required: trap_req_o=0 immediately; all CSRs at reset values; mtimecmp reads 0xFFFFFFFF.
- VECTORED_MODE_EN:
  - Stimulus: mtvec=0x201, irq 2 enabled and taken.
  - Required: trap_addr_o=0x200+4*18=0x248. With the macro undefined, trap_addr_o=0x200 and mtvec reads 0x200.

Source files
------------

// File: rtl/irq_trap_ctrl.sv
// irq_trap_ctrl: machine-mode interrupt CSRs, timer, arbitration and
// trap handshake with pipe_ctrl.
// Ports: clk_i/rst_i (async active-low), irq_i (async levels),
//   csr_raddr_i/csr_rdata_o (comb read), csr_we_i/waddr/wdata (WB write),
//   inst_valid_i/epc_i (interruptible EXE instr), mret_i,
//   trap_req_o/trap_addr_o/trap_ack_i (redirect handshake), mepc_o.
// Option: define VECTORED_MODE_EN for mtvec mode 01 vectoring.
module irq_trap_ctrl #(
  parameter int NUM_IRQ        = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_IRQ-1:0]        irq_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_raddr_i,
  output logic [DATA_WIDTH-1:0]     csr_rdata_o,
  input  logic                      csr_we_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
  input  logic [DATA_WIDTH-1:0]     csr_wdata_i,
  input  logic                      inst_valid_i,
  input  logic [ADDR_WIDTH-1:0]     epc_i,
  input  logic                      mret_i,
  output logic                      trap_req_o,
  output logic [ADDR_WIDTH-1:0]     trap_addr_o,
  input  logic                      trap_ack_i,
  output logic [ADDR_WIDTH-1:0]     mepc_o
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [CSR_ADDR_WIDTH-1:0] A_MSTATUS =
    CSR_ADDR_WIDTH'(12'h300);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MIE =
    CSR_ADDR_WIDTH'(12'h304);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MIP =
    CSR_ADDR_WIDTH'(12'h344);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MTVEC =
    CSR_ADDR_WIDTH'(12'h305);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MEPC =
    CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MCAUSE =
    CSR_ADDR_WIDTH'(12'h342);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MTIME =
    CSR_ADDR_WIDTH'(12'h7C0);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MTCMP =
    CSR_ADDR_WIDTH'(12'h7C1);

  localparam logic [DATA_WIDTH-1:0] MIE_MASK =
    DATA_WIDTH'(((64'd1 << NUM_IRQ) - 64'd1) << 16) |
    DATA_WIDTH'(64'h80);
  localparam logic [DATA_WIDTH-1:0] LOW2 = DATA_WIDTH'(3);
`ifdef VECTORED_MODE_EN
  localparam logic [DATA_WIDTH-1:0] MTVEC_MASK = '1;
`else
  localparam logic [DATA_WIDTH-1:0] MTVEC_MASK = ~LOW2;
`endif

  state_t                  state;
  logic [NUM_IRQ-1:0]      sync1, sync2;
  logic [DATA_WIDTH-1:0]   mie_q, mtvec_q, mepc_q, mcause_q;
  logic [DATA_WIDTH-1:0]   mtime_q, mtcmp_q;
  logic                    st_mie, st_mpie;
  logic [4:0]              cause_q, cause_d;
  logic [DATA_WIDTH-1:0]   mip, enabled, mstatus;
  logic [ADDR_WIDTH-1:0]   base, target;
  logic                    mtip, take, mret_go;
  logic                    wr_mst, wr_mie, wr_mtvec;
  logic                    wr_mepc, wr_mcause, wr_mtcmp;

  assign mtip    = (mtime_q >= mtcmp_q);
  assign enabled = mip & mie_q;
  assign mstatus = DATA_WIDTH'({st_mpie, 3'b000, st_mie, 3'b000});
  assign mepc_o  = ADDR_WIDTH'(mepc_q);

  always_comb begin
    mip = '0;
    mip[7] = mtip;
    mip[16 +: NUM_IRQ] = sync2;
  end

  // Timer wins; descending scan leaves the lowest irq index.
  always_comb begin
    cause_d = 5'd7;
    if (!enabled[7]) begin
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
        if (enabled[16 + k]) cause_d = 5'(16 + k);
      end
    end
  end

  assign base = ADDR_WIDTH'(mtvec_q) & ~ADDR_WIDTH'(3);
`ifdef VECTORED_MODE_EN
  assign target = (mtvec_q[1:0] == 2'b01) ?
    base + (ADDR_WIDTH'(cause_d) << 2) : base;
`else
  assign target = base;
`endif

  // mret takes precedence over a same-cycle trap.
  assign mret_go = (state == IDLE) && mret_i;
  assign take = (state == IDLE) && st_mie && (|enabled) &&
    inst_valid_i && !mret_i;

  assign wr_mst    = csr_we_i && (csr_waddr_i == A_MSTATUS);
  assign wr_mie    = csr_we_i && (csr_waddr_i == A_MIE);
  assign wr_mtvec  = csr_we_i && (csr_waddr_i == A_MTVEC);
  assign wr_mepc   = csr_we_i && (csr_waddr_i == A_MEPC);
  assign wr_mcause = csr_we_i && (csr_waddr_i == A_MCAUSE);
  assign wr_mtcmp  = csr_we_i && (csr_waddr_i == A_MTCMP);

  always_comb begin
    csr_rdata_o = '0;
    unique case (1'b1)
      (csr_raddr_i == A_MSTATUS): csr_rdata_o = mstatus;
      (csr_raddr_i == A_MIE):     csr_rdata_o = mie_q;
      (csr_raddr_i == A_MIP):     csr_rdata_o = mip;
      (csr_raddr_i == A_MTVEC):   csr_rdata_o = mtvec_q;
      (csr_raddr_i == A_MEPC):    csr_rdata_o = mepc_q;
      (csr_raddr_i == A_MCAUSE):  csr_rdata_o = mcause_q;
      (csr_raddr_i == A_MTIME):   csr_rdata_o = mtime_q;
      (csr_raddr_i == A_MTCMP):   csr_rdata_o = mtcmp_q;
      default:                    csr_rdata_o = '0;
    endcase
  end

  // Later assignments override: trap/mret updates beat CSR writes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      sync1       <= '0;
      sync2       <= '0;
      mie_q       <= '0;
      mtvec_q     <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtime_q     <= '0;
      mtcmp_q     <= '1;
      st_mie      <= 1'b0;
      st_mpie     <= 1'b0;
      cause_q     <= '0;
      trap_req_o  <= 1'b0;
      trap_addr_o <= '0;
    end else begin
      mtime_q <= mtime_q + DATA_WIDTH'(1);
      sync1   <= irq_i;
      sync2   <= sync1;
      if (wr_mie)    mie_q    <= csr_wdata_i & MIE_MASK;
      if (wr_mtvec)  mtvec_q  <= csr_wdata_i & MTVEC_MASK;
      if (wr_mtcmp)  mtcmp_q  <= csr_wdata_i;
      if (wr_mepc)   mepc_q   <= csr_wdata_i & ~LOW2;
      if (wr_mcause) mcause_q <= csr_wdata_i;
      if (wr_mst) begin
        st_mie  <= csr_wdata_i[3];
        st_mpie <= csr_wdata_i[7];
      end
      if (mret_go) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (take) begin
            state       <= REQ;
            trap_req_o  <= 1'b1;
            cause_q     <= cause_d;
            trap_addr_o <= target;
          end
        end
        REQ: begin
          if (trap_ack_i) begin
            state      <= IDLE;
            trap_req_o <= 1'b0;
            mepc_q     <= DATA_WIDTH'(epc_i) & ~LOW2;
            mcause_q   <= {1'b1, (DATA_WIDTH-1)'(cause_q)};
            st_mpie    <= st_mie;
            st_mie     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
